// File: rtl/seq_det_multi.sv
// Multi-channel serial pattern detector: shared bit history, per-channel
// programmable pattern/length, overlap mode, and saturating match counters.
module seq_det_lane #(
    parameter int MAX_LEN = 4,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = 3
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               in_valid,
    input  logic               overlap,
    input  logic               sel,
    input  logic               cnt_clr,
    input  logic [MAX_LEN-1:0] hist_nxt,
    input  logic [MAX_LEN-1:0] cfg_pat,
    input  logic [LEN_W-1:0]   cfg_len,
    output logic               match,
    output logic [CNT_W-1:0]   cnt
);
    logic [MAX_LEN-1:0] pat;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   fill;
    logic               full;
    logic               det;

    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (i < int'(len));
    end

    // Enough bits seen once the completing bit arrives.
    assign full = ((LEN_W+1)'(fill) + (LEN_W+1)'(1)) >= (LEN_W+1)'(len);
    assign det  = in_valid && (len != '0) && full && !sel &&
                  ((hist_nxt & mask) == (pat & mask));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pat   <= '0;
            len   <= '0;
            fill  <= '0;
            match <= 1'b0;
            cnt   <= '0;
        end else begin
            match <= det;
            if (sel) begin
                pat <= cfg_pat;
                len <= cfg_len;
            end
            if (sel)
                fill <= '0;
            else if (in_valid) begin
                if (det && !overlap)
                    fill <= '0;
                else if (fill != LEN_W'(MAX_LEN))
                    fill <= fill + 1'b1;
            end
            if (sel || cnt_clr)
                cnt <= '0;
            else if (det && (cnt != '1))
                cnt <= cnt + 1'b1;
        end
    end
endmodule

module seq_det_multi #(
    parameter int N_PAT   = 2,
    parameter int MAX_LEN = 4,
    parameter int CNT_W   = 8,
    localparam int IDX_W  = (N_PAT > 1) ? $clog2(N_PAT) : 1,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   in,
    input  logic                   in_valid,
    input  logic                   overlap,
    input  logic                   cfg_we,
    input  logic [IDX_W-1:0]       cfg_idx,
    input  logic [MAX_LEN-1:0]     cfg_pat,
    input  logic [LEN_W-1:0]       cfg_len,
    input  logic                   cnt_clr,
    output logic [N_PAT-1:0]       match,
    output logic [N_PAT*CNT_W-1:0] match_cnt
);
    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] hist_nxt;

    // Channels compare against the history as it will look after this bit.
    assign hist_nxt = {hist[MAX_LEN-2:0], in};

    always_ff @(posedge clk) begin
        if (!rstn)
            hist <= '0;
        else if (in_valid)
            hist <= hist_nxt;
    end

    genvar k;
    generate
        for (k = 0; k < N_PAT; k++) begin : g_lane
            logic sel;
            assign sel = cfg_we && (cfg_idx == IDX_W'(k));
            seq_det_lane #(
                .MAX_LEN (MAX_LEN),
                .CNT_W   (CNT_W),
                .LEN_W   (LEN_W)
            ) u_lane (
                .clk      (clk),
                .rstn     (rstn),
                .in_valid (in_valid),
                .overlap  (overlap),
                .sel      (sel),
                .cnt_clr  (cnt_clr),
                .hist_nxt (hist_nxt),
                .cfg_pat  (cfg_pat),
                .cfg_len  (cfg_len),
                .match    (match[k]),
                .cnt      (match_cnt[k*CNT_W +: CNT_W])
            );
        end
    endgenerate
endmodule
